// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, converter states and double-dabble step
// Purpose: display channel codes, BCD digit width, converter state encoding and
//          one add-3/shift iteration of the 7-bit to 2-digit double-dabble.
// Ports:   none (package).
package seg7_pkg;

   localparam logic [1:0] CH_BLANK = 2'd0;
   localparam logic [1:0] CH_ONES  = 2'd1;
   localparam logic [1:0] CH_TENS  = 2'd2;
   localparam int         DIGIT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_UPDATE = 2'd2
   } conv_state_t;

   // Working register layout: [14:11] tens, [10:7] ones, [6:0] binary.
   // Correct both digits that would overflow past 9 after the shift, then shift.
   function automatic logic [14:0] dd_step(input logic [14:0] s);
      logic [14:0] t;
      t = s;
      if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

endpackage

// File: rtl/seg7_scan_0_99_bin2bcd_seq.sv
// rtl/seg7_scan_0_99_bin2bcd_seq.sv - sequential 7-bit binary to two-digit BCD converter
// Purpose: IDLE -> SHIFT (7 iterations) -> UPDATE -> IDLE double-dabble engine.
// Ports:   clk, rst        clock, async active-high reset
//          load, value     start strobe (ignored unless idle), binary 0..99
//          busy, done      conversion running, one-cycle completion pulse
//          tens, ones      last completed result (held stable during conversion)
//          upd             high during the UPDATE cycle
//          upd_tens/ones   result that tens/ones take at the end of the UPDATE cycle
import seg7_pkg::*;

module bin2bcd_seq (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [6:0]         value,
   output logic               busy,
   output logic               done,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               upd,
   output logic [DIGIT_W-1:0] upd_tens,
   output logic [DIGIT_W-1:0] upd_ones
);

   conv_state_t state;
   logic [14:0] work;
   logic [2:0]  iter;

   assign upd      = (state == ST_UPDATE);
   assign upd_tens = work[14:11];
   assign upd_ones = work[10:7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         work  <= '0;
         iter  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         tens  <= '0;
         ones  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  work  <= {8'd0, value};
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               work <= dd_step(work);
               iter <= iter + 3'd1;
               if (iter == 3'd6) state <= ST_UPDATE;
            end
            ST_UPDATE: begin
               tens  <= work[14:11];
               ones  <= work[10:7];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_0_99.sv
// rtl/seg7_scan_0_99.sv - two-digit multiplexed 7-segment drive with BCD conversion
// Purpose: saturates and converts a 0..99 value to BCD, then scans tens/ones onto
//          bcd/disp_channel, each slot held REFRESH_DIV clocks.
//          Optional macro LEADING_ZERO_BLANK_EN blanks the tens slot when tens==0.
// Ports:   clk, rst        clock, async active-high reset
//          value, load     binary input and load request (honoured when busy=0)
//          busy, done      conversion in progress, one-cycle new-digits pulse
//          ovf             sticky: last accepted value exceeded SAT_MAX
//          bcd             digit presented in the current slot
//          disp_channel    2 = tens slot, 1 = ones slot, 0 = blank
import seg7_pkg::*;

module seg7_scan_0_99 #(
   parameter int REFRESH_DIV = 50,
   parameter int SAT_MAX     = 99
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         value,
   input  logic               load,
   output logic               busy,
   output logic               done,
   output logic               ovf,
   output logic [DIGIT_W-1:0] bcd,
   output logic [1:0]         disp_channel
);

   localparam int         CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [6:0] SAT_LIM = 7'(SAT_MAX);

   logic               accept;
   logic [6:0]         sat_value;
   logic [DIGIT_W-1:0] tens, ones, upd_tens, upd_ones;
   logic [DIGIT_W-1:0] tens_cur, ones_cur;
   logic               upd;
   logic [CW-1:0]      cnt;
   logic               slot;       // 0 = tens slot, 1 = ones slot
   logic               slot_next;
   logic               wrap;

   assign accept    = load & ~busy;
   assign sat_value = (value > SAT_LIM) ? SAT_LIM : value;

   bin2bcd_seq u_conv (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .value    (sat_value),
      .busy     (busy),
      .done     (done),
      .tens     (tens),
      .ones     (ones),
      .upd      (upd),
      .upd_tens (upd_tens),
      .upd_ones (upd_ones)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         ovf <= 1'b0;
      else if (accept) ovf <= (value > SAT_LIM);
   end

   // The output register samples the digits being committed in UPDATE so new
   // digits appear on the same edge as done, whichever slot is active.
   assign tens_cur  = upd ? upd_tens : tens;
   assign ones_cur  = upd ? upd_ones : ones;
   assign wrap      = (cnt == CW'(REFRESH_DIV - 1));
   assign slot_next = wrap ? ~slot : slot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         slot         <= 1'b0;
         bcd          <= '0;
         disp_channel <= CH_TENS;
      end else begin
         cnt  <= wrap ? '0 : cnt + 1'b1;
         slot <= slot_next;
         if (slot_next) begin
            disp_channel <= CH_ONES;
            bcd          <= ones_cur;
         end else begin
`ifdef LEADING_ZERO_BLANK_EN
            if (tens_cur == '0) begin
               disp_channel <= CH_BLANK;
               bcd          <= '0;
            end else begin
               disp_channel <= CH_TENS;
               bcd          <= tens_cur;
            end
`else
            disp_channel <= CH_TENS;
            bcd          <= tens_cur;
`endif
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_0_99.sv
// tb/tb_seg7_scan_0_99.sv - self-checking bench for seg7_scan_0_99
module tb_seg7_scan_0_99;

   localparam int DIV = 4;
   localparam int SAT = 99;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [6:0] value;
   logic       busy, done, ovf;
   logic [3:0] bcd;
   logic [1:0] disp_channel;

   always #5 clk = ~clk;

   seg7_scan_0_99 #(.REFRESH_DIV(DIV), .SAT_MAX(SAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .value        (value),
      .load         (load),
      .busy         (busy),
      .done         (done),
      .ovf          (ovf),
      .bcd          (bcd),
      .disp_channel (disp_channel)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out", name);
   endtask

   // Reference model: edges counted since reset release; a load at edge k is
   // accepted if no conversion is pending, digits commit at edge k+8.
   int m_ec, m_last, m_pt, m_po, m_t, m_o, m_v;
   bit m_ovf, m_done;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ec = 0; m_last = -100; m_t = 0; m_o = 0; m_ovf = 0; m_done = 0;
      end else begin
         m_ec++;
         m_done = (m_ec == m_last + 8);
         if (m_done) begin
            m_t = m_pt;
            m_o = m_po;
         end
         if (load && m_ec >= m_last + 9) begin
            m_last = m_ec;
            m_v    = (int'(value) > SAT) ? SAT : int'(value);
            m_pt   = m_v / 10;
            m_po   = m_v % 10;
            m_ovf  = int'(value) > SAT;
         end
      end
   end

   function automatic int tens_chan(input int t);
      return (LZB && t == 0) ? 0 : 2;
   endfunction

   function automatic int exp_chan();
      return (((m_ec / DIV) % 2) == 1) ? 1 : tens_chan(m_t);
   endfunction

   function automatic int exp_bcd();
      if (((m_ec / DIV) % 2) == 1) return m_o;
      return (LZB && m_t == 0) ? 0 : m_t;
   endfunction

   function automatic int exp_busy();
      return ((m_ec - m_last) >= 0 && (m_ec - m_last) <= 7) ? 1 : 0;
   endfunction

   bit sb_en = 1'b0;

   always @(negedge clk) begin
      if (sb_en && !rst) begin
         chk("sb_busy", 32'(busy), 32'(exp_busy()));
         chk("sb_done", 32'(done), 32'(m_done));
         chk("sb_ovf", 32'(ovf), 32'(m_ovf));
         chk("sb_chan", 32'(disp_channel), 32'(exp_chan()));
         chk("sb_bcd", 32'(bcd), 32'(exp_bcd()));
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy) timeout_fail("wait_idle");
   endtask

   task automatic do_load(input int v);
      wait_idle();
      value = 7'(v);
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      if (!done) timeout_fail("wait_done");
   endtask

   task automatic collect(output int t, output int o);
      t = 0;
      o = 0;
      repeat (2 * DIV) begin
         @(negedge clk);
         if (disp_channel == 2'd2) t = int'(bcd);
         if (disp_channel == 2'd1) o = int'(bcd);
      end
   endtask

   typedef struct {
      int v;
      int t;
      int o;
      bit ov;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int t, o, bc, dpos, dcnt;
      tbl[0] = '{0, 0, 0, 0};
      tbl[1] = '{99, 9, 9, 0};
      tbl[2] = '{100, 9, 9, 1};
      tbl[3] = '{127, 9, 9, 1};
      tbl[4] = '{57, 5, 7, 0};
      tbl[5] = '{120, 9, 9, 1};
      tbl[6] = '{3, 0, 3, 0};
      tbl[7] = '{10, 1, 0, 0};
      tbl[8] = '{45, 4, 5, 0};
      tbl[9] = '{9, 0, 9, 0};

      rst = 1'b1; load = 1'b0; value = '0;
      repeat (3) @(negedge clk);
      chk("rst_bcd", 32'(bcd), 0);
      chk("rst_chan", 32'(disp_channel), 2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(ovf), 0);
      #2 rst = 1'b0;
      sb_en = 1'b1;

      // Slot timing: toggle to ones at edge 4, period 8.
      repeat (3) @(negedge clk);
      chk("slot_edge3", 32'(disp_channel), 32'(tens_chan(0)));
      @(negedge clk);
      chk("slot_edge4", 32'(disp_channel), 1);
      repeat (4) @(negedge clk);
      chk("slot_edge8", 32'(disp_channel), 32'(tens_chan(0)));
      repeat (4) @(negedge clk);
      chk("slot_edge12", 32'(disp_channel), 1);

      // Latency of a single conversion.
      do_load(57);
      chk("lat_busy0", 32'(busy), 1);
      bc = busy ? 1 : 0;
      dpos = -1;
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done && dpos < 0) begin
            dpos = i;
            chk("lat_digit_at_done", 32'(bcd), (disp_channel == 2'd1) ? 7 : 5);
         end
      end
      chk("lat_busy_cycles", 32'(bc), 8);
      chk("lat_done_pos", 32'(dpos), 8);
      collect(t, o);
      chk("lat_tens", 32'(t), 5);
      chk("lat_ones", 32'(o), 7);

      foreach (tbl[i]) begin
         do_load(tbl[i].v);
         wait_done();
         collect(t, o);
         chk($sformatf("tbl%0d_tens", tbl[i].v), 32'(t), 32'(tbl[i].t));
         chk($sformatf("tbl%0d_ones", tbl[i].v), 32'(o), 32'(tbl[i].o));
         chk($sformatf("tbl%0d_ovf", tbl[i].v), 32'(ovf), 32'(tbl[i].ov));
      end

      for (int i = 0; i < 100; i++) begin
         do_load(i);
         wait_done();
         collect(t, o);
         chk($sformatf("sweep%0d_tens", i), 32'(t), 32'(i / 10));
         chk($sformatf("sweep%0d_ones", i), 32'(o), 32'(i % 10));
      end

      // Load while busy is dropped.
      do_load(57);
      @(negedge clk);
      value = 7'd12;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      wait_done();
      collect(t, o);
      chk("drop_tens", 32'(t), 5);
      chk("drop_ones", 32'(o), 7);

      // Reset in the middle of a conversion.
      do_load(88);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_bcd", 32'(bcd), 0);
      chk("midrst_chan", 32'(disp_channel), 2);
      @(negedge clk);
      #2 rst = 1'b0;
      dcnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("midrst_no_done", 32'(dcnt), 0);
      collect(t, o);
      chk("midrst_tens", 32'(t), 0);
      chk("midrst_ones", 32'(o), 0);
      chk("midrst_ovf", 32'(ovf), 0);

      // Random loads, including loads while busy, against the model.
      repeat (600) begin
         @(negedge clk);
         load  = ($urandom_range(0, 3) == 0);
         value = 7'($urandom_range(0, 127));
      end
      @(negedge clk);
      load = 1'b0;
      repeat (20) @(negedge clk);

      sb_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
